// File: rtl/mem_stage_if.sv
// EXE->MEM->WB pipeline link for the memory stage: handshake, buses, SRAM read data, forward bus.
interface mem_stage_if #(
  parameter int ES_TO_MS_BUS_WD = 71,
  parameter int MS_TO_WS_BUS_WD = 70,
  parameter int MS_FWD_BUS_WD   = 37
) ();
  logic                       ws_allowin;
  logic                       ms_allowin;
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic [31:0]                data_sram_rdata;
  logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus;

  modport slave (
    input  ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_rdata,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus
  );

  modport master (
    output ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_rdata,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus
  );
endinterface

// File: rtl/mem_stage.sv
// CPU memory stage: registers the EXE bus, selects load data or ALU result, and
// buffers synchronous SRAM read data while WB stalls.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 71,
  parameter int MS_TO_WS_BUS_WD = 70,
  parameter int MS_FWD_BUS_WD   = 37
) (
  input  logic         clk,
  input  logic         resetn,
  mem_stage_if.slave   pipe
);

  logic                       ms_valid;
  logic                       ms_first;
  logic                       ms_ready_go;
  logic                       ms_allowin;
  logic                       ms_to_ws_valid;
  logic                       accept;
  logic                       rdata_buf_valid;
  logic [31:0]                rdata_buf;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus_r;

  logic                       ms_res_from_mem;
  logic                       ms_gr_we;
  logic [4:0]                 ms_dest;
  logic [31:0]                ms_alu_result;
  logic [31:0]                ms_pc;
  logic [31:0]                load_data;
  logic [31:0]                final_result;
  logic [MS_TO_WS_BUS_WD-1:0] ws_bus;
  logic [MS_FWD_BUS_WD-1:0]   fwd_bus;

  assign ms_ready_go    = 1'b1;
  assign ms_allowin     = !ms_valid || (ms_ready_go && pipe.ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign accept         = pipe.es_to_ms_valid && ms_allowin;

  assign ms_res_from_mem = es_to_ms_bus_r[70];
  assign ms_gr_we        = es_to_ms_bus_r[69];
  assign ms_dest         = es_to_ms_bus_r[68:64];
  assign ms_alu_result   = es_to_ms_bus_r[63:32];
  assign ms_pc           = es_to_ms_bus_r[31:0];

  // SRAM data is only valid in the first MEM cycle; later cycles use the buffered copy.
  assign load_data    = rdata_buf_valid ? rdata_buf : pipe.data_sram_rdata;
  assign final_result = ms_res_from_mem ? load_data : ms_alu_result;

  assign ws_bus  = {ms_gr_we, ms_dest, final_result, ms_pc};
  assign fwd_bus = {final_result, ms_dest & {5{ms_valid}}};

  assign pipe.ms_allowin     = ms_allowin;
  assign pipe.ms_to_ws_valid = ms_to_ws_valid;
  assign pipe.ms_to_ws_bus   = ws_bus;
  assign pipe.ms_fwd_bus     = fwd_bus;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid        <= 1'b0;
      ms_first        <= 1'b0;
      rdata_buf_valid <= 1'b0;
      rdata_buf       <= '0;
      es_to_ms_bus_r  <= '0;
    end else begin
      if (ms_allowin) ms_valid <= pipe.es_to_ms_valid;
      if (accept)     es_to_ms_bus_r <= pipe.es_to_ms_bus;
      ms_first <= accept;
      // Capture and release are exclusive: capture needs !ws_allowin, release needs ws_allowin.
      if (ms_to_ws_valid && pipe.ws_allowin) begin
        rdata_buf_valid <= 1'b0;
      end else if (ms_valid && ms_first && !pipe.ws_allowin) begin
        rdata_buf_valid <= 1'b1;
        rdata_buf       <= pipe.data_sram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table with a WB-side scoreboard,
// plus stall, back-pressure and asynchronous-reset sequences.
module tb_mem_stage;
  localparam int ES_W  = 71;
  localparam int WS_W  = 70;
  localparam int FWD_W = 37;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  mem_stage_if #(.ES_TO_MS_BUS_WD(ES_W), .MS_TO_WS_BUS_WD(WS_W), .MS_FWD_BUS_WD(FWD_W)) bus_if ();

  mem_stage #(.ES_TO_MS_BUS_WD(ES_W), .MS_TO_WS_BUS_WD(WS_W), .MS_FWD_BUS_WD(FWD_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .pipe   (bus_if)
  );

  typedef struct {
    logic        v;
    logic        rfm;
    logic        we;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] ld;   // data the SRAM returns in this instruction's first MEM cycle
  } instr_t;

  logic [WS_W-1:0] exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic m_valid = 1'b0;

  function automatic void chk(string name, logic [69:0] act, logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [ES_W-1:0] pack_es(instr_t i);
    return {i.rfm, i.we, i.dest, i.alu, i.pc};
  endfunction

  function automatic logic [WS_W-1:0] exp_ws(instr_t i);
    return {i.we, i.dest, (i.rfm ? i.ld : i.alu), i.pc};
  endfunction

  // One clock: drive at posedge+1, sample at posedge+4, update the model.
  task automatic cycle(input instr_t i, input logic [31:0] rdata, input logic wsa);
    logic            m_allowin;
    logic [WS_W-1:0] e;
    @(posedge clk);
    #1;
    bus_if.es_to_ms_valid  = i.v;
    bus_if.es_to_ms_bus    = pack_es(i);
    bus_if.data_sram_rdata = rdata;
    bus_if.ws_allowin      = wsa;
    #3;
    m_allowin = !m_valid || wsa;
    chk("ms_allowin", 70'(bus_if.ms_allowin), 70'(m_allowin));
    chk("ms_to_ws_valid", 70'(bus_if.ms_to_ws_valid), 70'(m_valid));
    if (!bus_if.ms_to_ws_valid) begin
      chk("fwd_dest_bubble", 70'(bus_if.ms_fwd_bus[4:0]), 70'(0));
    end else if (wsa) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: got output %h expected none", bus_if.ms_to_ws_bus);
      end else begin
        e = exp_q.pop_front();
        chk("ms_to_ws_bus", 70'(bus_if.ms_to_ws_bus), 70'(e));
        chk("ms_fwd_bus", 70'(bus_if.ms_fwd_bus), 70'({e[63:32], e[68:64]}));
      end
    end
    if (i.v && m_allowin) exp_q.push_back(exp_ws(i));
    if (m_allowin) m_valid = i.v;
  endtask

  instr_t vec[10];
  instr_t bub, ld1, nw, ld2, ld_rst, ld3;

  initial begin
    vec[0] = '{1'b1, 1'b0, 1'b1, 5'd5,  32'h1234_5678, 32'h1c00_0000, 32'hA5A5_A5A5};
    vec[1] = '{1'b1, 1'b1, 1'b1, 5'd10, 32'h0000_0040, 32'h1c00_0004, 32'hDEAD_BEEF};
    vec[2] = '{1'b0, 1'b0, 1'b1, 5'd7,  32'h7777_7777, 32'h1c00_0008, 32'h0000_0000};
    vec[3] = '{1'b1, 1'b1, 1'b1, 5'd31, 32'h0000_0000, 32'h1c00_000c, 32'hFFFF_FFFF};
    vec[4] = '{1'b1, 1'b1, 1'b0, 5'd0,  32'h0000_0001, 32'h1c00_0010, 32'h0000_0000};
    vec[5] = '{1'b1, 1'b0, 1'b0, 5'd1,  32'h8000_0000, 32'h1c00_0014, 32'h7FFF_FFFF};
    vec[6] = '{1'b0, 1'b0, 1'b0, 5'd0,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vec[7] = '{1'b0, 1'b1, 1'b1, 5'd9,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vec[8] = '{1'b1, 1'b1, 1'b1, 5'd2,  32'hFFFF_0000, 32'h1c00_0018, 32'h0000_0080};
    vec[9] = '{1'b0, 1'b0, 1'b0, 5'd0,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    bub    = '{1'b0, 1'b0, 1'b0, 5'd0,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    ld1    = '{1'b1, 1'b1, 1'b1, 5'd7,  32'h1111_1111, 32'h0000_0100, 32'hCAFE_0001};
    nw     = '{1'b1, 1'b0, 1'b1, 5'd9,  32'h5555_5555, 32'h0000_0200, 32'h0000_0000};
    ld2    = '{1'b1, 1'b1, 1'b1, 5'd3,  32'h0000_0000, 32'h0000_0300, 32'h1357_2468};
    ld_rst = '{1'b1, 1'b1, 1'b1, 5'd6,  32'h0000_0000, 32'h0000_0400, 32'h0F0F_0F0F};
    ld3    = '{1'b1, 1'b1, 1'b1, 5'd4,  32'h0000_0000, 32'h0000_0500, 32'h2468_ACE0};

    resetn                 = 1'b0;
    bus_if.es_to_ms_valid  = 1'b0;
    bus_if.es_to_ms_bus    = '0;
    bus_if.data_sram_rdata = '0;
    bus_if.ws_allowin      = 1'b1;
    #12;
    chk("reset_allowin", 70'(bus_if.ms_allowin), 70'(1));
    chk("reset_ms_to_ws_valid", 70'(bus_if.ms_to_ws_valid), 70'(0));
    chk("reset_fwd_bus", 70'(bus_if.ms_fwd_bus), 70'(0));
    #5;
    resetn = 1'b1;

    // Table: WB always ready, SRAM returns the previous vector's load data.
    for (int k = 0; k < 10; k++) begin
      cycle(vec[k], (k > 0) ? vec[k-1].ld : 32'h0, 1'b1);
    end

    // Load held across a 3-cycle WB stall while EXE offers a new instruction.
    cycle(ld1, 32'h0, 1'b1);
    cycle(nw, 32'hCAFE_0001, 1'b0);
    chk("stall_final_c1", 70'(bus_if.ms_to_ws_bus[63:32]), 70'(32'hCAFE_0001));
    for (int s = 2; s <= 3; s++) begin
      cycle(nw, 32'hFFFF_FFFF, 1'b0);
      chk("stall_final", 70'(bus_if.ms_to_ws_bus[63:32]), 70'(32'hCAFE_0001));
      chk("stall_bus_held_pc", 70'(bus_if.ms_to_ws_bus[31:0]), 70'(32'h0000_0100));
      chk("stall_bus_held_dest", 70'(bus_if.ms_to_ws_bus[68:64]), 70'(5'd7));
    end
    cycle(nw, 32'hFFFF_FFFF, 1'b1);
    cycle(ld2, 32'h0BAD_F00D, 1'b1);
    cycle(bub, 32'h1357_2468, 1'b1);
    cycle(bub, 32'h0, 1'b1);

    // Asynchronous reset in the middle of a stalled load with buffered data.
    cycle(ld_rst, 32'h0, 1'b1);
    cycle(bub, 32'hAAAA_5555, 1'b0);
    cycle(bub, 32'hAAAA_5555, 1'b0);
    resetn = 1'b0;
    #1;
    chk("async_rst_valid", 70'(bus_if.ms_to_ws_valid), 70'(0));
    chk("async_rst_fwd", 70'(bus_if.ms_fwd_bus), 70'(0));
    chk("async_rst_allowin", 70'(bus_if.ms_allowin), 70'(1));
    exp_q.delete();
    m_valid = 1'b0;
    @(posedge clk);
    #3;
    resetn = 1'b1;
    cycle(ld3, 32'h0, 1'b1);
    cycle(bub, 32'h2468_ACE0, 1'b1);
    cycle(bub, 32'h0, 1'b1);

    chk("scoreboard_empty", 70'(exp_q.size()), 70'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
